// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable Moore sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_e;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparator: history and pattern are compared on their low len bits only.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  localparam int unsigned LEN_W  = len_width(MAX_LEN)
) (
  input  logic [MAX_LEN-1:0] history_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               eq_o
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_i) mask[i] = 1'b1;
    end
    eq_o = ((history_i ^ pattern_i) & mask) == '0;
  end

endmodule

// File: rtl/seq_detect_moore.sv
// Programmable Moore serial sequence detector with saturating hit counter.
// Optional sticky_hit output is built when SEQ_DETECT_MOORE_STICKY_EN is defined.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = len_width(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               code,
  input  logic               code_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
`ifdef SEQ_DETECT_MOORE_STICKY_EN
  ,
  output logic               sticky_hit
`endif
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_sat;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_d;
  logic               y_q, armed_q, err_q;
  logic [LEN_W:0]     fill_inc;
  logic               len_legal, pat_eq, hit;

  assign hist_shift = {hist_q[MAX_LEN-2:0], code};
  assign fill_inc   = {1'b0, fill_q} + 1'b1;
  assign fill_sat   = (fill_inc > {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
  assign len_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  seq_match_cmp #(
    .MAX_LEN(MAX_LEN)
  ) u_cmp (
    .history_i(hist_shift),
    .pattern_i(pat_q),
    .len_i    (len_q),
    .eq_o     (pat_eq)
  );

  assign hit = (fill_inc >= {1'b0, len_q}) && pat_eq;

  // Load has priority over data: a bit arriving with cfg_load is dropped.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (cfg_load) begin
      cnt_d = '0;
      if (len_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        state_d = RUN;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end else if (state_q != IDLE) begin
      state_d = RUN;
      if (code_valid) begin
        hist_d = hist_shift;
        fill_d = fill_sat;
        if (hit) begin
          state_d = HIT;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!ovl_q) fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      y_q     <= (state_d == HIT);
      armed_q <= (state_d != IDLE);
      err_q   <= err_d;
    end
  end

  assign y           = y_q;
  assign armed       = armed_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

`ifdef SEQ_DETECT_MOORE_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else if (cfg_load && len_legal) begin
      sticky_q <= 1'b0;
    end else if (state_d == HIT) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_hit = sticky_q;
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed table-driven bench for seq_detect_moore plus hand-written corner sequences.
module tb_seq_detect_moore;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       code, code_valid, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y, armed, cfg_err;
  logic [7:0] match_count;
  logic       y2, armed2, cfg_err2;
  logic [1:0] match_count2;
`ifdef SEQ_DETECT_MOORE_STICKY_EN
  logic       sticky_hit, sticky_hit2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seq_detect_moore #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .code(code), .code_valid(code_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .y(y), .armed(armed), .cfg_err(cfg_err),
    .match_count(match_count)
`ifdef SEQ_DETECT_MOORE_STICKY_EN
    , .sticky_hit(sticky_hit)
`endif
  );

  seq_detect_moore #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .code(code), .code_valid(code_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .y(y2), .armed(armed2), .cfg_err(cfg_err2),
    .match_count(match_count2)
`ifdef SEQ_DETECT_MOORE_STICKY_EN
    , .sticky_hit(sticky_hit2)
`endif
  );

  typedef struct {
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       code;
    logic       ey;
    logic       earm;
    logic       eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t ld(logic [7:0] pat, logic [3:0] len, logic ovl, logic vld,
                              logic c, logic earm, logic eerr, logic [7:0] ecnt);
    vec_t v;
    v.load = 1'b1; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.code = c;
    v.ey = 1'b0; v.earm = earm; v.eerr = eerr; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic vec_t bt(logic vld, logic c, logic ey, logic earm, logic [7:0] ecnt);
    vec_t v;
    v.load = 1'b0; v.pat = '0; v.len = '0; v.ovl = 1'b0; v.vld = vld; v.code = c;
    v.ey = ey; v.earm = earm; v.eerr = 1'b0; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cfg_load = v.load; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ovl;
    code_valid = v.vld; code = v.code;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic ay, input logic aarm, input logic aerr,
                       input logic [7:0] acnt, input logic ey, input logic earm,
                       input logic eerr, input logic [7:0] ecnt);
    n_vec++;
    if ({ay, aarm, aerr, acnt} !== {ey, earm, eerr, ecnt}) begin
      n_bad++;
      $display("FAIL %s: got y=%b armed=%b err=%b cnt=%0d, want y=%b armed=%b err=%b cnt=%0d",
               name, ay, aarm, aerr, acnt, ey, earm, eerr, ecnt);
    end
  endtask

  initial begin
    // test 1: non-overlap 110
    vecs.push_back(ld(8'b110, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 1, 1, 1));
    vecs.push_back(bt(0, 0, 0, 1, 1));
    // test 2: overlap on 11
    vecs.push_back(ld(8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 1, 1, 1, 1));
    vecs.push_back(bt(1, 1, 1, 1, 2));
    vecs.push_back(bt(1, 1, 1, 1, 3));
    vecs.push_back(bt(0, 0, 0, 1, 3));
    // test 2: non-overlap on 11
    vecs.push_back(ld(8'b11, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 1, 1, 1, 1));
    vecs.push_back(bt(1, 1, 0, 1, 1));
    vecs.push_back(bt(1, 1, 1, 1, 2));
    vecs.push_back(bt(0, 0, 0, 1, 2));
    // test 3: gapped 110
    vecs.push_back(ld(8'b110, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(bt(0, 0, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(bt(0, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(bt(0, 0, 0, 1, 1));
    // test 4: illegal len 0, stream ignored
    vecs.push_back(ld(8'b110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
    vecs.push_back(bt(1, 1, 0, 0, 0));
    vecs.push_back(bt(1, 1, 0, 0, 0));
    vecs.push_back(bt(1, 0, 0, 0, 0));
    // illegal len above MAX_LEN
    vecs.push_back(ld(8'b110, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
    vecs.push_back(bt(0, 0, 0, 0, 0));
    // load colliding with a valid 1: bit dropped, so 1,0 alone cannot complete 110
    vecs.push_back(ld(8'b110, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 1, 1, 1));
    // full-length pattern A5
    vecs.push_back(ld(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 0, 1, 0));
    vecs.push_back(bt(1, 0, 0, 1, 0));
    vecs.push_back(bt(1, 1, 0, 1, 0));
    vecs.push_back(bt(1, 0, 0, 1, 0));
    vecs.push_back(bt(1, 1, 1, 1, 1));
    vecs.push_back(bt(1, 1, 0, 1, 1));

    reset_n = 1'b0; code = 1'b0; code_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("reset", y, armed, cfg_err, match_count, 0, 0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), y, armed, cfg_err, match_count,
            vecs[i].ey, vecs[i].earm, vecs[i].eerr, vecs[i].ecnt);
    end

    // test 5: reset while y is high
    drive(ld(8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    drive(bt(1, 1, 0, 1, 0));
    drive(bt(1, 1, 0, 1, 0));
    check("pre_reset_hit", y, armed, cfg_err, match_count, 1, 1, 0, 1);
    reset_n = 1'b0;
    drive(bt(1, 1, 0, 0, 0));
    check("reset_in_hit", y, armed, cfg_err, match_count, 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(bt(1, 1, 0, 0, 0));
    check("post_reset_idle", y, armed, cfg_err, match_count, 0, 0, 0, 0);

    // test 6: len=1 with 2-bit saturating counter
    drive(ld(8'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    check("sat_load", y2, armed2, cfg_err2, {6'd0, match_count2}, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(bt(1, 1, 0, 1, 0));
      check($sformatf("sat%0d", i), y2, armed2, cfg_err2, {6'd0, match_count2},
            1, 1, 0, (i > 3) ? 8'd3 : 8'(i));
      check($sformatf("wide%0d", i), y, armed, cfg_err, match_count, 1, 1, 0, 8'(i));
    end
    drive(bt(1, 0, 0, 1, 0));
    check("sat_hold", y2, armed2, cfg_err2, {6'd0, match_count2}, 0, 1, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
